// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register completer.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } slv_state_t;

  localparam int ADDR_LSB   = 2;
  localparam int ID_REG_IDX = 0;

  // Word-aligned accesses only; any set byte-offset bit is an error.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// 4-bit loadable down-counter pacing the wait states of an APB access phase.
module apb_wait_ctr (
  input  logic       pclk,
  input  logic       preset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero_next
);

  logic [3:0] cnt_r;

  // Load on setup, otherwise count down while the access phase is stalled.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  assign zero_next = (cnt_r == 4'd1);

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with a word-addressed register bank, programmable wait states and pslverr.
// Optional build macro APB_SLV_XFER_CNT_EN turns the last register into a read-only transfer counter.
import apb_pkg::*;

module apb_reg_slave #(
  parameter int                ADDR_WIDTH  = 32,
  parameter int                DATA_WIDTH  = 32,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA9B0_0001
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic                           pselx,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int                    IDX_W      = $clog2(NUM_REGS);
  localparam int                    WORD_W     = ADDR_WIDTH - ADDR_LSB;
  localparam logic [WORD_W-1:0]     NUM_REGS_W = WORD_W'(NUM_REGS);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0]      ID_IDX     = IDX_W'(ID_REG_IDX);
  localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_STATES);
  localparam logic                  HAS_WAIT   = (WAIT_STATES != 0);

  slv_state_t state_r;
  slv_state_t next_state_s;

  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  wr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  err_r;

  logic [ADDR_WIDTH-1:0] cur_addr_s;
  logic                  cur_wr_s;
  logic [WORD_W-1:0]     word_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  wr_cnt_s;
  logic                  err_s;
  logic [DATA_WIDTH-1:0] rd_val_s;

  logic                  ld_s;
  logic                  dec_s;
  logic                  resp_s;
  logic                  zero_next_s;
  logic                  commit_s;

  logic                  nx_pready_s;
  logic                  nx_pslverr_s;
  logic [DATA_WIDTH-1:0] nx_prdata_s;
  logic                  pready_r;
  logic                  pslverr_r;
  logic [DATA_WIDTH-1:0] prdata_r;

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

`ifdef APB_SLV_XFER_CNT_EN
  logic [DATA_WIDTH-1:0] xfer_cnt_r;
`endif

  apb_wait_ctr u_wait_ctr (
    .pclk      (pclk),
    .preset    (preset),
    .load      (ld_s),
    .load_val  (WAIT_LOAD),
    .dec       (dec_s),
    .zero_next (zero_next_s)
  );

  // Decode straight from the bus during setup so a zero-wait access can respond next cycle.
  always_comb begin
    if (state_r == IDLE) begin
      cur_addr_s = paddr;
      cur_wr_s   = pwrite;
    end else begin
      cur_addr_s = addr_r;
      cur_wr_s   = wr_r;
    end
    word_s = cur_addr_s[ADDR_WIDTH-1:ADDR_LSB];
    idx_s  = cur_addr_s[ADDR_LSB +: IDX_W];
  end

`ifdef APB_SLV_XFER_CNT_EN
  assign wr_cnt_s = cur_wr_s && (idx_s == LAST_IDX);
`else
  assign wr_cnt_s = 1'b0;
`endif

  assign err_s = is_misaligned(cur_addr_s[1:0]) || (word_s >= NUM_REGS_W) ||
                 (cur_wr_s && (idx_s == ID_IDX)) || wr_cnt_s;

  // Read mux over the ID constant, the optional counter and the storage registers.
  always_comb begin
    if (idx_s == ID_IDX) begin
      rd_val_s = ID_VALUE;
`ifdef APB_SLV_XFER_CNT_EN
    end else if (idx_s == LAST_IDX) begin
      rd_val_s = xfer_cnt_r;
`endif
    end else begin
      rd_val_s = regs_r[idx_s];
    end
  end

  // State register.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and the values the output registers take on the following edge.
  always_comb begin
    next_state_s = state_r;
    ld_s         = 1'b0;
    dec_s        = 1'b0;
    resp_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (pselx && !penable) begin
          ld_s = 1'b1;
          if (HAS_WAIT) begin
            next_state_s = WAIT;
          end else begin
            next_state_s = RESP;
            resp_s       = 1'b1;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        dec_s = 1'b1;
        if (!pselx) begin
          next_state_s = IDLE;
        end else if (zero_next_s) begin
          next_state_s = RESP;
          resp_s       = 1'b1;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase

    nx_pready_s  = resp_s;
    nx_pslverr_s = resp_s && err_s;
    if (resp_s && !err_s && !cur_wr_s) begin
      nx_prdata_s = rd_val_s;
    end else begin
      nx_prdata_s = '0;
    end
  end

  // Capture the transfer at setup; the error flag is frozen with it.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      addr_r  <= '0;
      wr_r    <= 1'b0;
      wdata_r <= '0;
      err_r   <= 1'b0;
    end else if (ld_s) begin
      addr_r  <= paddr;
      wr_r    <= pwrite;
      wdata_r <= pwdata;
      err_r   <= err_s;
    end
  end

  // Registered APB response outputs.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= '0;
    end else begin
      pready_r  <= nx_pready_s;
      pslverr_r <= nx_pslverr_s;
      prdata_r  <= nx_prdata_s;
    end
  end

  assign pready  = pready_r;
  assign pslverr = pslverr_r;
  assign prdata  = prdata_r;

  // A transfer only takes effect if the master is still selecting us at the RESP edge.
  assign commit_s = (state_r == RESP) && pselx && !err_r;

  // Register bank write port.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (commit_s && wr_r) begin
      regs_r[idx_s] <= wdata_r;
    end
  end

`ifdef APB_SLV_XFER_CNT_EN
  // Completed-transfer counter, wraps naturally.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      xfer_cnt_r <= '0;
    end else if (commit_s) begin
      xfer_cnt_r <= xfer_cnt_r + DATA_WIDTH'(1);
    end
  end
`endif

  // Flat register image for the peripheral core.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == ID_REG_IDX) begin
        regs_o[i*DATA_WIDTH +: DATA_WIDTH] = ID_VALUE;
`ifdef APB_SLV_XFER_CNT_EN
      end else if (i == NUM_REGS - 1) begin
        regs_o[i*DATA_WIDTH +: DATA_WIDTH] = xfer_cnt_r;
`endif
      end else begin
        regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_r[i];
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: one zero-wait and one three-wait instance driven by APB transfers.
module tb_apb_reg_slave;

  localparam int          AW = 32;
  localparam int          DW = 32;
  localparam int          NR = 8;
  localparam logic [31:0] ID = 32'hA9B0_0001;
`ifdef APB_SLV_XFER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              pclk = 1'b0;
  logic              preset;
  logic              pselx_a   [2];
  logic              penable_a [2];
  logic              pwrite_a  [2];
  logic [AW-1:0]     paddr_a   [2];
  logic [DW-1:0]     pwdata_a  [2];
  logic              pready_a  [2];
  logic              pslverr_a [2];
  logic [DW-1:0]     prdata_a  [2];
  logic [NR*DW-1:0]  regs_o_a  [2];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [2][NR];

  always #5 pclk = ~pclk;

  apb_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(0), .ID_VALUE(ID)) u0 (
    .pclk(pclk), .preset(preset), .pselx(pselx_a[0]), .penable(penable_a[0]), .pwrite(pwrite_a[0]),
    .paddr(paddr_a[0]), .pwdata(pwdata_a[0]), .pready(pready_a[0]), .pslverr(pslverr_a[0]),
    .prdata(prdata_a[0]), .regs_o(regs_o_a[0]));

  apb_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(3), .ID_VALUE(ID)) u1 (
    .pclk(pclk), .preset(preset), .pselx(pselx_a[1]), .penable(penable_a[1]), .pwrite(pwrite_a[1]),
    .paddr(paddr_a[1]), .pwdata(pwdata_a[1]), .pready(pready_a[1]), .pslverr(pslverr_a[1]),
    .prdata(prdata_a[1]), .regs_o(regs_o_a[1]));

  typedef struct {
    int          s;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [14];

  function automatic int ws(input int s);
    return (s == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input int s, input string name);
    logic [NR*DW-1:0] act;
    logic [NR*DW-1:0] exp;
    act = regs_o_a[s];
    for (int i = 0; i < NR; i++) exp[i*DW +: DW] = (i == 0) ? ID : model[s][i];
    if (CNT_EN) begin
      act[(NR-1)*DW +: DW] = '0;
      exp[(NR-1)*DW +: DW] = '0;
    end
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NR; i++) model[s][i] = 32'h0;
  endtask

  task automatic setup(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    pselx_a[s]   = 1'b1;
    penable_a[s] = 1'b0;
    pwrite_a[s]  = wr;
    paddr_a[s]   = addr;
    pwdata_a[s]  = wd;
  endtask

  // Full transfer; returns one negedge after the RESP cycle with pselx still high.
  task automatic xfer(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int lat);
    setup(s, wr, addr, wd);
    @(negedge pclk);
    penable_a[s] = 1'b1;
    lat = 0;
    while (pready_a[s] !== 1'b1 && lat < 40) begin
      lat++;
      @(negedge pclk);
    end
    rd  = prdata_a[s];
    err = pslverr_a[s];
    @(negedge pclk);
  endtask

  task automatic idle(input int s);
    pselx_a[s]   = 1'b0;
    penable_a[s] = 1'b0;
    @(negedge pclk);
  endtask

  task automatic good_xfer(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input string name);
    logic [31:0] rd;
    logic        err;
    int          lat;
    xfer(s, wr, addr, wd, rd, err, lat);
    chk({name, "_lat"}, 32'(lat), 32'(ws(s)));
    chk({name, "_err"}, 32'(err), 32'h0);
    chk({name, "_rd"}, rd, exp_rd);
    if (wr) model[s][addr[4:2]] = wd;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;

    vecs[0]  = '{0, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0,   32'h0};
    vecs[1]  = '{0, 1'b0, 32'h0000_0004, 32'h0,         1'b0,   32'h1234_5678};
    vecs[2]  = '{1, 1'b0, 32'h0000_0000, 32'h0,         1'b0,   ID};
    vecs[3]  = '{0, 1'b1, 32'h0000_0000, 32'hFFFF_0000, 1'b1,   32'h0};
    vecs[4]  = '{0, 1'b1, 32'h0000_0002, 32'h55AA_55AA, 1'b1,   32'h0};
    vecs[5]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         1'b1,   32'h0};
    vecs[6]  = '{1, 1'b1, 32'h0000_000C, 32'hA5A5_5A5A, 1'b0,   32'h0};
    vecs[7]  = '{1, 1'b0, 32'h0000_000C, 32'h0,         1'b0,   32'hA5A5_5A5A};
    vecs[8]  = '{1, 1'b0, 32'h4000_0004, 32'h0,         1'b1,   32'h0};
    vecs[9]  = '{1, 1'b0, 32'h0000_001E, 32'h0,         1'b1,   32'h0};
    vecs[10] = '{1, 1'b1, 32'h0000_001C, 32'hCAFE_F00D, CNT_EN, 32'h0};
    vecs[11] = '{0, 1'b0, 32'h0000_0014, 32'h0,         1'b0,   32'h0};
    vecs[12] = '{0, 1'b1, 32'h0000_0024, 32'h0000_0001, 1'b1,   32'h0};
    vecs[13] = '{1, 1'b0, 32'h0000_0003, 32'h0,         1'b1,   32'h0};

    preset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      pselx_a[s] = 1'b0; penable_a[s] = 1'b0; pwrite_a[s] = 1'b0;
      paddr_a[s] = 32'h0; pwdata_a[s] = 32'h0;
    end
    clear_model();
    #2;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_pready%0d", s), 32'(pready_a[s]), 32'h0);
      chk($sformatf("rst_pslverr%0d", s), 32'(pslverr_a[s]), 32'h0);
      chk($sformatf("rst_prdata%0d", s), prdata_a[s], 32'h0);
      chk_regs(s, $sformatf("rst_regs%0d", s));
    end
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);

    // Table: function, wait-state latency and error decode.
    for (int i = 0; i < 14; i++) begin
      xfer(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, err, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(ws(vecs[i].s)));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
      chk($sformatf("v%0d_rd", i), rd, vecs[i].rd);
      if (vecs[i].wr && !vecs[i].err) model[vecs[i].s][vecs[i].addr[4:2]] = vecs[i].wd;
      chk_regs(vecs[i].s, $sformatf("v%0d_regs", i));
      idle(vecs[i].s);
    end
    if (!CNT_EN) good_xfer(1, 1'b0, 32'h0000_001C, 32'h0, 32'hCAFE_F00D, "r7_rw");
    idle(1);

    // Reset while the zero-wait instance is presenting a response.
    setup(0, 1'b0, 32'h0000_0000, 32'h0);
    @(negedge pclk);
    penable_a[0] = 1'b1;
    chk("t4_resp_before_rst", 32'(pready_a[0]), 32'h1);
    #2 preset = 1'b1;
    #1;
    chk("t4_rst_pready", 32'(pready_a[0]), 32'h0);
    chk("t4_rst_prdata", prdata_a[0], 32'h0);
    clear_model();
    pselx_a[0] = 1'b0; penable_a[0] = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    chk_regs(0, "t4_regs0_cleared");
    chk_regs(1, "t4_regs1_cleared");

    // Reset in the middle of the wait phase of a write to reg 2.
    setup(1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    @(negedge pclk);
    penable_a[1] = 1'b1;
    @(negedge pclk);
    #2 preset = 1'b1;
    #1;
    chk("t4_wait_rst_pready", 32'(pready_a[1]), 32'h0);
    chk("t4_wait_rst_reg2", regs_o_a[1][95:64], 32'h0);
    @(negedge pclk);
    preset = 1'b0;
    repeat (6) @(negedge pclk);
    chk("t4_reg2_no_write", regs_o_a[1][95:64], 32'h0);
    chk("t4_cnt_reset", regs_o_a[0][(NR-1)*DW +: DW], 32'h0);
    good_xfer(1, 1'b1, 32'h0000_0008, 32'h1111_2222, 32'h0, "t4_after_w");
    good_xfer(1, 1'b0, 32'h0000_0008, 32'h0, 32'h1111_2222, "t4_after_r");
    idle(1);
    chk_regs(1, "t4_after_regs");

`ifdef APB_SLV_XFER_CNT_EN
    good_xfer(0, 1'b1, 32'h0000_0004, 32'h0000_00A1, 32'h0, "t5_g1");
    good_xfer(0, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_00A1, "t5_g2");
    good_xfer(0, 1'b1, 32'h0000_0008, 32'h0000_00B2, 32'h0, "t5_g3");
    good_xfer(0, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_00B2, "t5_g4");
    good_xfer(0, 1'b0, 32'h0000_0000, 32'h0, ID, "t5_g5");
    xfer(0, 1'b1, 32'h0000_001C, 32'h0000_0077, rd, err, lat);
    chk("t5_cnt_write_err", 32'(err), 32'h1);
    good_xfer(0, 1'b0, 32'h0000_001C, 32'h0, 32'h0000_0005, "t5_cnt5");
    idle(0);
    force u0.xfer_cnt_r = 32'hFFFF_FFFF;
    @(negedge pclk);
    release u0.xfer_cnt_r;
    good_xfer(0, 1'b0, 32'h0000_001C, 32'h0, 32'hFFFF_FFFF, "t5_cnt_max");
    good_xfer(0, 1'b0, 32'h0000_001C, 32'h0, 32'h0000_0000, "t5_cnt_wrap");
    idle(0);
    chk_regs(0, "t5_regs");
`endif

    // Back-to-back alternating write/read with pselx held high throughout.
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 4; j++) begin
        if ((j % 2) == 0)
          good_xfer(s, 1'b1, 32'h10 + 32'(j / 2) * 32'h4, 32'h3C3C_0000 + 32'(j + 16 * s), 32'h0,
                    $sformatf("t6_s%0d_%0d", s, j));
        else
          good_xfer(s, 1'b0, 32'h10 + 32'(j / 2) * 32'h4, 32'h0, 32'h3C3C_0000 + 32'(j - 1 + 16 * s),
                    $sformatf("t6_s%0d_%0d", s, j));
      end
      idle(s);
      chk_regs(s, $sformatf("t6_regs%0d", s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
